// File: rtl/cmp_arbiter.sv
// -----------------------------------------------------------------------------
// cmp_arbiter
//
// Two-requester round-robin arbiter and sequencer in front of a shared 4-bit
// unsigned magnitude comparator. A request is accepted over a valid/ready
// handshake and its operands are registered. They are then held on the
// comparator for HOLD_CYCLES cycles. The one-hot result (A>B, A==B, A<B) is
// returned with the requester id over a valid/ready response channel.
//
// Parameters
//   WIDTH        operand width; must be 4 to match the comparator.
//   HOLD_CYCLES  cycles the operands stay on the comparator before sampling,
//                1..15.
//
// Ports
//   clk                   system clock, rising edge
//   rst                   asynchronous reset, active high
//   req0_valid/ready/a/b  requester 0 request channel
//   req1_valid/ready/a/b  requester 1 request channel
//   rsp_valid/ready       response handshake
//   rsp_id                requester that owns the result
//   rsp_agb/aeb/alb       one-hot compare result (A>B, A==B, A<B)
//   busy                  high whenever the sequencer is not IDLE
//
// Optional build macro
//   CMP_ARB_STATS_EN  adds 8-bit saturating grant counters gnt_cnt0/gnt_cnt1.
// -----------------------------------------------------------------------------

// Combinational unsigned magnitude comparator shared by both requesters.
module cmp_arbiter_mag #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             agb_o,
    output logic             aeb_o,
    output logic             alb_o
);

    // Exactly one of the three outputs is high for any operand pair.
    always_comb begin
        agb_o = (a_i > b_i);
        aeb_o = (a_i == b_i);
        alb_o = (a_i < b_i);
    end

endmodule

module cmp_arbiter #(
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic             rsp_agb,
    output logic             rsp_aeb,
    output logic             rsp_alb,
    output logic             busy
`ifdef CMP_ARB_STATS_EN
    ,
    output logic [7:0]       gnt_cnt0,
    output logic [7:0]       gnt_cnt1
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Counter value seen on the last EVAL cycle.
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t           state_q, state_d;
    logic             rr_last_q, rr_last_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             op_id_q, op_id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic             rsp_agb_q, rsp_agb_d;
    logic             rsp_aeb_q, rsp_aeb_d;
    logic             rsp_alb_q, rsp_alb_d;
    logic             busy_q;

    logic             gnt0_s;
    logic             gnt1_s;
    logic             hs_s;
    logic             cmp_agb_s;
    logic             cmp_aeb_s;
    logic             cmp_alb_s;

    cmp_arbiter_mag #(
        .WIDTH (WIDTH)
    ) u_mag (
        .a_i   (op_a_q),
        .b_i   (op_b_q),
        .agb_o (cmp_agb_s),
        .aeb_o (cmp_aeb_s),
        .alb_o (cmp_alb_s)
    );

    // Round-robin grant: only in IDLE and never while reset is asserted.
    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if ((state_q == ST_IDLE) && !rst) begin
            if (req0_valid && req1_valid) begin
                gnt0_s = rr_last_q;
                gnt1_s = !rr_last_q;
            end else begin
                gnt0_s = req0_valid;
                gnt1_s = req1_valid;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // A grant is only given to a valid requester, so grant means handshake.
    assign hs_s       = gnt0_s | gnt1_s;
    assign req0_ready = gnt0_s;
    assign req1_ready = gnt1_s;

    // Next-state and datapath control for the IDLE -> EVAL -> RESP sequence.
    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_id_d     = op_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_agb_d   = rsp_agb_q;
        rsp_aeb_d   = rsp_aeb_q;
        rsp_alb_d   = rsp_alb_q;
        case (state_q)
            ST_IDLE: begin
                if (hs_s) begin
                    op_a_d    = gnt1_s ? req1_a : req0_a;
                    op_b_d    = gnt1_s ? req1_b : req0_b;
                    op_id_d   = gnt1_s;
                    rr_last_d = gnt1_s;
                    cnt_d     = 4'd0;
                    state_d   = ST_EVAL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EVAL: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == HOLD_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = op_id_q;
                    rsp_agb_d   = cmp_agb_s;
                    rsp_aeb_d   = cmp_aeb_s;
                    rsp_alb_d   = cmp_alb_s;
                    state_d     = ST_RESP;
                end else begin
                    state_d = ST_EVAL;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_id_d    = 1'b0;
                    rsp_agb_d   = 1'b0;
                    rsp_aeb_d   = 1'b0;
                    rsp_alb_d   = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                rsp_id_d    = 1'b0;
                rsp_agb_d   = 1'b0;
                rsp_aeb_d   = 1'b0;
                rsp_alb_d   = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State, operand and response registers; reset discards any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_last_q   <= 1'b1;
            cnt_q       <= 4'd0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_id_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_agb_q   <= 1'b0;
            rsp_aeb_q   <= 1'b0;
            rsp_alb_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_agb_q   <= rsp_agb_d;
            rsp_aeb_q   <= rsp_aeb_d;
            rsp_alb_q   <= rsp_alb_d;
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_agb   = rsp_agb_q;
    assign rsp_aeb   = rsp_aeb_q;
    assign rsp_alb   = rsp_alb_q;
    assign busy      = busy_q;

`ifdef CMP_ARB_STATS_EN
    logic [7:0] gnt_cnt0_q;
    logic [7:0] gnt_cnt1_q;

    // Saturating per-requester handshake counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_cnt0_q <= 8'd0;
            gnt_cnt1_q <= 8'd0;
        end else begin
            if (gnt0_s && (gnt_cnt0_q != 8'hFF)) begin
                gnt_cnt0_q <= gnt_cnt0_q + 8'd1;
            end
            if (gnt1_s && (gnt_cnt1_q != 8'hFF)) begin
                gnt_cnt1_q <= gnt_cnt1_q + 8'd1;
            end
        end
    end

    assign gnt_cnt0 = gnt_cnt0_q;
    assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_cmp_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cmp_arbiter
//
// Self-checking bench for cmp_arbiter. An accept-side monitor predicts the
// ready/busy outputs from a round-robin model and pushes the expected result
// (plain unsigned arithmetic on the accepted operands) into a scoreboard.
// A separate response monitor checks each returned result against it.
// Directed scenarios are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_cmp_arbiter;

    localparam int HOLD = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       v0, v1;
    logic [3:0] a0, b0, a1, b1;
    logic       r0, r1;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_agb, rsp_aeb, rsp_alb;
    logic       busy;
`ifdef CMP_ARB_STATS_EN
    logic [7:0] gnt_cnt0, gnt_cnt1;
`endif

    cmp_arbiter #(
        .WIDTH       (4),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (v0),
        .req0_ready (r0),
        .req0_a     (a0),
        .req0_b     (b0),
        .req1_valid (v1),
        .req1_ready (r1),
        .req1_a     (a1),
        .req1_b     (b1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_agb    (rsp_agb),
        .rsp_aeb    (rsp_aeb),
        .rsp_alb    (rsp_alb),
        .busy       (busy)
`ifdef CMP_ARB_STATS_EN
        ,
        .gnt_cnt0   (gnt_cnt0),
        .gnt_cnt1   (gnt_cnt1)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic id;
        logic agb;
        logic aeb;
        logic alb;
        int   hs_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   rd_idx = 0;

    // Reference model state (written only by the accept monitor).
    logic m_idle  = 1'b1;
    logic m_last  = 1'b1;
    int   hs_cnt0 = 0;
    int   hs_cnt1 = 0;
    int   m_gnt0  = 0;
    int   m_gnt1  = 0;

    // Accept monitor: predict ready/busy, record accepted requests.
    always @(negedge clk) begin
        logic g0, g1;
        exp_t e;
        if (rst) begin
            chk("rst_ready0", {31'd0, r0}, 32'd0);
            chk("rst_ready1", {31'd0, r1}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_rsp", {28'd0, rsp_valid, rsp_id, rsp_agb, rsp_aeb | rsp_alb}, 32'd0);
            m_idle = 1'b1;
            m_last = 1'b1;
            m_gnt0 = 0;
            m_gnt1 = 0;
        end else begin
            g0 = m_idle && v0 && (!v1 || m_last);
            g1 = m_idle && v1 && (!v0 || !m_last);
            chk("ready0", {31'd0, r0}, {31'd0, g0});
            chk("ready1", {31'd0, r1}, {31'd0, g1});
            chk("busy", {31'd0, busy}, {31'd0, !m_idle});
`ifdef CMP_ARB_STATS_EN
            chk("gnt_cnt0", {24'd0, gnt_cnt0}, m_gnt0);
            chk("gnt_cnt1", {24'd0, gnt_cnt1}, m_gnt1);
`endif
            if (g0 || g1) begin
                e.id     = g1;
                e.agb    = g1 ? (a1 > b1)  : (a0 > b0);
                e.aeb    = g1 ? (a1 == b1) : (a0 == b0);
                e.alb    = g1 ? (a1 < b1)  : (a0 < b0);
                e.hs_cyc = cyc;
                sb_q.push_back(e);
                m_last = g1;
                m_idle = 1'b0;
                if (g1) begin
                    hs_cnt1++;
                    if (m_gnt1 < 255) m_gnt1++;
                end else begin
                    hs_cnt0++;
                    if (m_gnt0 < 255) m_gnt0++;
                end
            end else if (rsp_valid && rsp_ready) begin
                m_idle = 1'b1;
            end
        end
    end

    // Response monitor: pop and compare whenever a result is presented.
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_v = 1'b0;
            rd_idx = sb_q.size();
        end else begin
            if (rsp_valid) begin
                if (rd_idx >= sb_q.size()) begin
                    chk("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
                end else begin
                    e = sb_q[rd_idx];
                    if (!prev_v) chk("rsp_latency", cyc - e.hs_cyc, HOLD + 1);
                    chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
                    chk("rsp_result", {29'd0, rsp_agb, rsp_aeb, rsp_alb},
                        {29'd0, e.agb, e.aeb, e.alb});
                    if (rsp_ready) rd_idx++;
                end
            end else begin
                chk("rsp_idle_zero", {28'd0, rsp_id, rsp_agb, rsp_aeb, rsp_alb}, 32'd0);
            end
            prev_v = rsp_valid;
        end
    end

    int seen0 = 0;
    int seen1 = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        seen0 = hs_cnt0;
        seen1 = hs_cnt1;
    endtask

    task automatic wait_hs(input int id);
        int n = 0;
        while (((id == 1) ? hs_cnt1 : hs_cnt0) == ((id == 1) ? seen1 : seen0)) begin
            tick();
            n++;
            if (n > 60) begin
                chk("hs_timeout", 32'd1, 32'd0);
                break;
            end
        end
        seen0 = hs_cnt0;
        seen1 = hs_cnt1;
    endtask

    // Issue one request, then drop valid and scramble the operands.
    task automatic send(input int id, input logic [3:0] a, input logic [3:0] b);
        if (id == 1) begin
            v1 = 1'b1; a1 = a; b1 = b;
        end else begin
            v0 = 1'b1; a0 = a; b0 = b;
        end
        wait_hs(id);
        if (id == 1) begin
            v1 = 1'b0; a1 = 4'($urandom); b1 = 4'($urandom);
        end else begin
            v0 = 1'b0; a0 = 4'($urandom); b0 = 4'($urandom);
        end
    endtask

    // Both requesters stay valid; fresh operands after each of their grants.
    task automatic run_both(input int grants);
        int cnt = 0;
        int guard = 0;
        v0 = 1'b1;
        v1 = 1'b1;
        while (cnt < grants && guard < 300) begin
            tick();
            guard++;
            if (hs_cnt0 != seen0) begin
                seen0 = hs_cnt0; cnt++;
                a0 = 4'($urandom); b0 = 4'($urandom);
            end
            if (hs_cnt1 != seen1) begin
                seen1 = hs_cnt1; cnt++;
                a1 = 4'($urandom); b1 = 4'($urandom);
            end
        end
        if (guard >= 300) chk("both_timeout", 32'd1, 32'd0);
        v0 = 1'b0;
        v1 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        v0 = 1'b0; v1 = 1'b0;
        a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
        rsp_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Single request: 1010 vs 0111 -> A>B.
        send(0, 4'b1010, 4'b0111);
        repeat (4) tick();

        // Both valid from reset release: req0 first (equal), then req1 (less).
        do_reset();
        a0 = 4'b1001; b0 = 4'b1001;
        a1 = 4'b0111; b1 = 4'b1100;
        run_both(8);
        repeat (4) tick();

        // Response back-pressure while req1 waits.
        rsp_ready = 1'b0;
        send(0, 4'b0011, 4'b0101);
        v1 = 1'b1; a1 = 4'b0110; b1 = 4'b0010;
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("rsp_wait_timeout", 32'd1, 32'd0);
        repeat (5) tick();
        rsp_ready = 1'b1;
        wait_hs(1);
        v1 = 1'b0;
        repeat (4) tick();

        // Reset during EVAL of req1: the operation must vanish.
        send(1, 4'b1111, 4'b0000);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        seen0 = hs_cnt0;
        seen1 = hs_cnt1;
        repeat (3) tick();
        a0 = 4'b0100; b0 = 4'b0100;
        a1 = 4'b0001; b1 = 4'b1000;
        run_both(2);
        repeat (4) tick();

        // Randomized traffic with random back-pressure and early drops.
        for (int i = 0; i < 2000; i++) begin
            tick();
            rsp_ready = (($urandom % 4) != 0);
            if (hs_cnt0 != seen0) begin
                seen0 = hs_cnt0;
                v0 = (($urandom % 2) == 0);
                a0 = 4'($urandom); b0 = (($urandom % 4) == 0) ? a0 : 4'($urandom);
            end else if (v0) begin
                if (($urandom % 16) == 0) v0 = 1'b0;
            end else if (($urandom % 3) == 0) begin
                v0 = 1'b1;
                a0 = 4'($urandom); b0 = (($urandom % 4) == 0) ? a0 : 4'($urandom);
            end
            if (hs_cnt1 != seen1) begin
                seen1 = hs_cnt1;
                v1 = (($urandom % 2) == 0);
                a1 = 4'($urandom); b1 = (($urandom % 4) == 0) ? a1 : 4'($urandom);
            end else if (v1) begin
                if (($urandom % 16) == 0) v1 = 1'b0;
            end else if (($urandom % 3) == 0) begin
                v1 = 1'b1;
                a1 = 4'($urandom); b1 = (($urandom % 4) == 0) ? a1 : 4'($urandom);
            end
        end
        v0 = 1'b0;
        v1 = 1'b0;
        rsp_ready = 1'b1;
        repeat (6) tick();

`ifdef CMP_ARB_STATS_EN
        // Saturation of the grant counters.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            send(0, 4'($urandom), 4'($urandom));
        end
        repeat (4) tick();
        chk("gnt_cnt0_sat", {24'd0, gnt_cnt0}, 32'd255);
        chk("gnt_cnt1_zero", {24'd0, gnt_cnt1}, 32'd0);
`endif

        n = 0;
        while (rd_idx != sb_q.size() && n < 50) begin
            tick();
            n++;
        end
        chk("drain", rd_idx, sb_q.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
